// File: rtl/and_gate_arbiter.sv
// rtl/and_gate_arbiter.sv - shares one W-bit AND unit among N requesters with a tagged valid/ready result
// GATE_ARB_RR_EN selects round-robin arbitration; without it the lowest-index requester wins.
module and_gate_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  output logic [N-1:0]     gnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDW-1:0]   res_id,
  output logic [W-1:0]     res_data,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state;
  logic [W-1:0]   a_lat;
  logic [W-1:0]   b_lat;
  logic [IDW-1:0] id_lat;
  logic [IDW-1:0] win;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;

`ifdef GATE_ARB_RR_EN
  logic [IDW-1:0] ptr;
  logic [IDW:0]   cand;
  logic           found;

  // Scan ptr, ptr+1, ... wrapping at N; the first active requester wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N))
        cand = cand - (IDW+1)'(N);
      if (!found && req[cand[IDW-1:0]]) begin
        win   = cand[IDW-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (state == IDLE && |req)
      ptr <= (win == IDW'(N-1)) ? '0 : win + IDW'(1);
  end
`else
  always_comb begin
    win = '0;
    for (int i = N-1; i >= 0; i--)
      if (req[i])
        win = IDW'(i);
  end
`endif

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (win == IDW'(i)) begin
        a_sel = a_in[i*W +: W];
        b_sel = b_in[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      id_lat    <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            a_lat  <= a_sel;
            b_lat  <= b_sel;
            id_lat <= win;
            gnt    <= N'(1) << win;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= a_lat & b_lat;
          res_id    <= id_lat;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Requests are ignored here; they are only sampled again once IDLE is re-entered.
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_and_gate_arbiter.sv
// tb/tb_and_gate_arbiter.sv - randomized and directed checks of and_gate_arbiter against a transaction model
module tb_and_gate_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0] gnt;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [W-1:0] res_data;
  logic         busy;

  int n_pass = 0;
  int n_total = 0;

  and_gate_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Transaction model: phase 0 waiting, 1 granted, 2 result offered.
  int           m_phase = 0;
  int           m_ptr = 0;
  int           m_w;
  bit           m_known = 0;
  logic [N-1:0] m_gnt;
  logic         m_valid;
  logic [1:0]   m_id, m_pend_id;
  logic [W-1:0] m_data, m_pend_data;

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef GATE_ARB_RR_EN
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (r[i]) return i;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1; m_phase = 0; m_ptr = 0;
      m_gnt = '0; m_valid = 0; m_id = '0; m_data = '0;
    end else begin
      m_gnt = '0;
      if (m_phase == 0) begin
        if (req != '0) begin
          m_w = pick(req, m_ptr);
          m_pend_data = W'(a_in >> (m_w*W)) & W'(b_in >> (m_w*W));
          m_pend_id = 2'(m_w);
          m_gnt[m_w] = 1'b1;
          m_ptr = (m_w + 1) % N;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_valid = 1; m_id = m_pend_id; m_data = m_pend_data; m_phase = 2;
      end else if (res_ready) begin
        m_valid = 0; m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("res_valid", 32'(res_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("res_id", 32'(res_id), 32'(m_id));
      check("res_data", 32'(res_data), 32'(m_data));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; step(); rst = 1'b0;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (gnt != '0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
        return;
      end
    end
    check("grant_timeout", 32'(0), 32'(1));
  endtask

  int g;
`ifdef GATE_ARB_RR_EN
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int fp_exp[4] = '{1, 3, 1, 3};
`else
  int rr_exp[5] = '{0, 0, 0, 0, 0};
  int fp_exp[4] = '{1, 1, 1, 3};
`endif

  initial begin
    rst = 1'b1; req = 4'($urandom); res_ready = 1'b0;
    a_in = $urandom; b_in = $urandom;
    step(); req = 4'($urandom); step();
    check("rst_gnt", 32'(gnt), 0); check("rst_valid", 32'(res_valid), 0);
    check("rst_id", 32'(res_id), 0); check("rst_data", 32'(res_data), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0; req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_gnt", 32'(gnt), 0); check("idle_busy", 32'(busy), 0);
      check("idle_valid", 32'(res_valid), 0);
    end

    // Single transaction on requester 2.
    req = 4'b0100; a_in[2*W +: W] = 8'hF0; b_in[2*W +: W] = 8'h3C; res_ready = 1'b1;
    step(); req = '0;
    check("single_gnt", 32'(gnt), 32'b0100); check("single_busy", 32'(busy), 1);
    step();
    check("single_valid", 32'(res_valid), 1); check("single_id", 32'(res_id), 2);
    check("single_data", 32'(res_data), 32'h30);
    step();
    check("single_busy_low", 32'(busy), 0);

    do_reset();
    req = 4'b1111; res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g); check("rr_order", 32'(g), 32'(rr_exp[k]));
    end

    do_reset();
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_grant(g); check("prio_order", 32'(g), 32'(fp_exp[k]));
    end
    req = 4'b1000;
    wait_grant(g); check("prio_drop", 32'(g), 32'(fp_exp[3]));

    // Backpressure with operand changes after capture.
    do_reset(); step();
    req = 4'b0001; res_ready = 1'b0; a_in[W-1:0] = 8'hAA; b_in[W-1:0] = 8'h0F;
    wait_grant(g); check("bp_gnt", 32'(g), 0);
    req = '0; a_in = $urandom; b_in = $urandom;
    step();
    for (int k = 0; k < 4; k++) begin
      check("bp_valid", 32'(res_valid), 1); check("bp_id", 32'(res_id), 0);
      check("bp_data", 32'(res_data), 32'h0A); check("bp_gnt_quiet", 32'(gnt), 0);
      req = {3'($urandom), 1'b0};
      step();
    end
    res_ready = 1'b1; req = 4'b0100;
    check("bp_hold", 32'(res_data), 32'h0A);
    step();
    check("bp_idle_gnt", 32'(gnt), 0); check("bp_idle_valid", 32'(res_valid), 0);
    step();
    check("bp_next_gnt", 32'(gnt), 32'b0100);
    req = '0; step(); step(); step();

    // Reset during EXEC, then during RESP.
    do_reset();
    req = 4'b0010; step(); req = '0;
    check("mid_exec_gnt", 32'(gnt), 32'b0010);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_exec_valid", 32'(res_valid), 0); check("mid_exec_busy", 32'(busy), 0);
    step(); check("mid_exec_noresult", 32'(res_valid), 0);
    req = 4'b0001; res_ready = 1'b0; step(); req = '0; step();
    check("mid_resp_valid_pre", 32'(res_valid), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_resp_valid", 32'(res_valid), 0); check("mid_resp_busy", 32'(busy), 0);
    req = 4'b1111; res_ready = 1'b1; step();
    check("mid_ptr_restart", 32'(gnt), 32'b0001);
    req = '0; step(); step();

    // Randomized traffic: requesters hold req until granted and re-raise at random.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      a_in = $urandom; b_in = $urandom;
      res_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; req = '0; res_ready = 1'b1;
    step(); step(); step();
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/and_gate_arbiter.md
# and_gate_arbiter

Shares one W-bit bitwise AND unit among N requesters. A requester presents operands with a request, receives a one-cycle grant when its operands are captured, and receives a tagged result through a valid/ready response port. Sits between the requester blocks and the shared and_gate datapath. Grant order is round-robin by default and fixed-priority when the configuration macro is removed.

## Interface
- N, 4, number of requesters; legal range 2..8.
- W, 8, operand and result width in bits.
- IDW, $clog2(N), width of the requester ID; derived, not overridden.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request per requester; held high until the matching gnt bit is seen.
- a_in  in  N*W  operand A; requester i occupies bits [i*W +: W].
- b_in  in  N*W  operand B; same packing as a_in.
- gnt  out  N  one-hot, one-cycle pulse; operands of that requester captured this cycle.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_id  out  IDW  index of the requester that owns res_data.
- res_data  out  W  captured a & b.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE, req == 0: stay in IDLE.
- IDLE, any req bit high:
  - Select a winner.
  - Latch its a/b slices and its index.
  - Drive gnt onehot(winner) registered, so gnt is high during the first EXEC cycle.
  - Go to EXEC.
- EXEC: result register <= a_lat & b_lat (full W bits, no truncation); go to RESP.
- RESP: res_valid = 1; res_id and res_data are held stable.
  - res_valid && res_ready: go to IDLE, and clear res_valid next cycle.
  - Otherwise: stay in RESP, with req ignored.
- Requests are sampled only in IDLE. A requester drops req in the cycle after it sees gnt. A req still high when IDLE is re-entered counts as a new request.
- Round-robin arbitration:
  - Search starts at ptr and wraps from N-1 to 0.
  - After each grant, ptr <= winner+1 mod N.
  - ptr resets to 0.
- A single active requester always wins, whatever the value of ptr.
- Reset values: state = IDLE, gnt = 0, res_valid = 0, res_id = 0, res_data = 0, busy = 0, ptr = 0.
- Reset asserted in any state:
  - The in-flight transaction is discarded.
  - No gnt or res_valid is produced for it.
  - Reset wins over every simultaneous event.

## Timing
- Cycle t: in IDLE with req sampled.
- Cycle t+1: gnt pulse; state is EXEC.
- Cycle t+2: res_valid rises.
- Minimum req→res_valid latency is 2 cycles.
- If res_ready is high in the first RESP cycle, the transaction takes 3 cycles, and the next grant sample occurs at t+3.
- Peak throughput is one result per 3 cycles.
- busy is high from t+1 until the cycle in which the RESP handshake completes, inclusive.
- Operand changes after the capture edge at t+1 do not affect res_data.

## Configuration
- GATE_ARB_RR_EN defined (default build): round-robin arbitration using ptr as described above.
- GATE_ARB_RR_EN undefined:
  - Fixed priority; the lowest-index active requester always wins.
  - ptr logic is removed from the netlist.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use N=4, W=8.
- Reset and idle:
  - Stimulus: hold rst 2 cycles with random req, then req=0 for 5 cycles.
  - Required: gnt=0, res_valid=0, res_id=0, res_data=0, busy=0 throughout.
- Single transaction:
  - Stimulus: req=4'b0100, a slice 2 = 8'hF0, b slice 2 = 8'h3C, res_ready=1.
  - Required: gnt=4'b0100 at t+1; res_valid with res_id=2 and res_data=8'h30 at t+2; busy low at t+3.
- Round-robin fairness (GATE_ARB_RR_EN defined):
  - Stimulus: req=4'b1111, each requester re-raising req in IDLE.
  - Required: grant order 0,1,2,3,0; ID 3 wraps to 0.
- Fixed priority (GATE_ARB_RR_EN undefined):
  - Stimulus: req=4'b1010 held continuously.
  - Required: every grant goes to requester 1.
  - Stimulus: drop req[1].
  - Required: the next grant goes to requester 3.
- Backpressure:
  - Stimulus: res_ready=0 for 4 cycles in RESP while other req bits toggle.
  - Required: res_valid, res_id, res_data stable; no gnt until one cycle after res_ready=1.
  - Stimulus: change operands after gnt.
  - Required: res_data unchanged.
- Reset mid-operation:
  - Stimulus: assert rst during EXEC, then during RESP.
  - Required: res_valid=0 and state IDLE after the rst edge; no result for the aborted request; ptr restarts at 0, so req=4'b1111 next grants requester 0.
